demux_dispatch: RTL and testbench
=================================

Name: demux_dispatch

Overview:
Write-side counterpart of the processor's 10-way source-select mux. It takes one data item plus a 4-bit destination select over a valid/ready handshake and delivers it to exactly one of ten destination channels. Each channel has its own valid/ready pair, and a registered one-entry holding stage sits between input and outputs. Out-of-range selects are dropped and counted, so a bad control word cannot wedge the datapath.

Parameters:
DW, 8, width of the data payload in bits.
N_DEST, 10, number of destination channels; legal select values are 0..N_DEST-1.
SEL_W, 4, select width in bits; must satisfy 2^SEL_W >= N_DEST.
CNT_W, 8, width of the drop counter in bits.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous reset, active-high.
in_valid  input  1  the upstream stage presents an item.
in_ready  output  1  the block accepts the item this cycle.
in_sel  input  SEL_W  destination index for the item.
in_data  input  DW  payload.
out_valid  output  N_DEST  one-hot, or zero; bit k means channel k holds an item.
out_ready  input  N_DEST  per-channel ready from the destinations.
out_data  output  DW  payload shared by all channels; meaningful only where out_valid is set.
out_sel  output  SEL_W  index of the channel currently holding an item.
err_sel  output  1  one-cycle pulse when an out-of-range select is accepted.
drop_cnt  output  CNT_W  saturating count of dropped items.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE.
  - out_valid=0, out_data=0, out_sel=0, err_sel=0, drop_cnt=0.
  - Any pending item is discarded.
  - While rst is high, in_ready=0.
- States:
  - IDLE: no item held.
  - HOLD: one item held in the output register.
- Accept condition (combinational):
  - in_ready = (state==IDLE) OR (state==HOLD AND out_ready[out_sel]==1).
  - A transfer happens when in_valid AND in_ready are both 1 at a rising edge.
  - in_ready must not depend on in_valid.
- Legal accept (in_sel < N_DEST):
  - At the same edge, out_data<=in_data and out_sel<=in_sel.
  - out_valid<=one-hot(in_sel); state<=HOLD.
  - Latency is one cycle: out_valid is visible in the cycle after acceptance.
- Illegal accept (in_sel >= N_DEST):
  - The item is consumed and dropped.
  - err_sel<=1 for exactly one cycle.
  - drop_cnt increments and saturates at all-ones; it never wraps.
  - out_data and out_sel are unchanged.
- HOLD:
  - out_valid[out_sel]=1; out_data and out_sel are stable until the channel handshakes.
  - Exactly one out_valid bit is high; all others are 0.
  - out_ready on non-selected channels is ignored.
- Release (HOLD with out_ready[out_sel]=1 at the edge):
  - If a new legal item is accepted at the same edge, load it and stay in HOLD. This gives back-to-back throughput of one item per cycle, including to a different channel.
  - If the new item is illegal, the held item is released, out_valid<=0, state<=IDLE, and err_sel pulses.
  - With no new item, out_valid<=0 and state<=IDLE.
- HOLD without ready: in_ready=0, so upstream stalls.
- Ordering: items leave in acceptance order. The block neither reorders nor duplicates.
- err_sel is 0 in every cycle not immediately following an illegal accept.
- Reset asserted mid-HOLD: outputs clear immediately (asynchronously) and the held item is lost.
- Reset deassertion: the block is in IDLE; in_ready rises combinationally in the first cycle with rst low.

Test Plan:
1. Single legal dispatch: in_sel=3, in_data=8'hA5, out_ready=all ones.
   - Next cycle out_valid=10'b0000001000, out_data=A5, out_sel=3.
   - One cycle later out_valid=0.
2. Backpressure then release: in_sel=9, data=8'h3C, out_ready[9]=0 for 4 cycles.
   - out_valid[9] and out_data=3C stay stable; in_ready=0 throughout.
   - Raising out_ready[9]=1 for one cycle releases the item and in_ready=1 that cycle.
3. Back-to-back to different channels: sel 0,1,2 with data 11,22,33 on consecutive cycles, ready all ones.
   - out_valid walks 0x001, 0x002, 0x004 on consecutive cycles with the matching data; no bubbles.
4. Illegal selects: in_sel=12, then in_sel=15.
   - err_sel pulses one cycle each; drop_cnt=2; out_valid stays 0.
   - Drive 300 illegal items: drop_cnt saturates at 255.
5. Illegal item while holding: HOLD on sel=5 with out_ready[5]=1 and in_sel=10 at the same edge.
   - Item on 5 is released; state goes to IDLE; err_sel pulses; drop_cnt+1.
6. Reset mid-HOLD: holding sel=7, assert rst between clock edges.
   - out_valid=0, drop_cnt=0 immediately without a clock edge.
   - After deassertion, in_ready=1 and a fresh sel=7 item dispatches normally.

Source files
------------

// File: rtl/demux_dispatch.sv
// One-in, N_DEST-out dispatcher with a single registered holding stage.
// Out-of-range selects are consumed, flagged on err_sel and counted in drop_cnt.
module demux_dispatch #(
  parameter int unsigned DW     = 8,
  parameter int unsigned N_DEST = 10,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [DW-1:0]     in_data,
  output logic [N_DEST-1:0] out_valid,
  input  logic [N_DEST-1:0] out_ready,
  output logic [DW-1:0]     out_data,
  output logic [SEL_W-1:0]  out_sel,
  output logic              err_sel,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic sel_legal;
  logic release_now;
  logic accept;

  always_comb begin
    out_valid = '0;
    for (int unsigned k = 0; k < N_DEST; k++) begin
      if (state_q == StHold && 32'(sel_q) == k) out_valid[k] = 1'b1;
    end
  end

  // Masking with out_valid avoids indexing out_ready with a raw select.
  assign release_now = (state_q == StHold) && |(out_ready & out_valid);
  assign in_ready    = !rst && ((state_q == StIdle) || release_now);
  assign accept      = in_valid && in_ready;
  assign sel_legal   = 32'(in_sel) < N_DEST;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (release_now) state_d = StIdle;
    if (accept) begin
      if (sel_legal) begin
        state_d = StHold;
        data_d  = in_data;
        sel_d   = in_sel;
      end else begin
        err_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data = data_q;
  assign out_sel  = sel_q;
  assign err_sel  = err_q;
  assign drop_cnt = cnt_q;

endmodule

// File: tb/tb_demux_dispatch.sv
// Directed bench for demux_dispatch: dispatch, backpressure, back-to-back,
// illegal selects, saturation and asynchronous reset mid-hold.
module tb_demux_dispatch;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_sel;
  logic [7:0] in_data;
  logic [9:0] out_valid;
  logic [9:0] out_ready;
  logic [7:0] out_data;
  logic [3:0] out_sel;
  logic       err_sel;
  logic [7:0] drop_cnt;

  int total;
  int bad;

  demux_dispatch #(
    .DW(8),
    .N_DEST(10),
    .SEL_W(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sel(in_sel),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_sel(out_sel),
    .err_sel(err_sel),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    total++; if (out_valid !== 10'h000) begin bad++; $display("FAIL rst_out_valid: got %h want 000", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data: got %h want 00", out_data); end
    total++; if (out_sel !== 4'h0) begin bad++; $display("FAIL rst_out_sel: got %h want 0", out_sel); end
    total++; if (err_sel !== 1'b0) begin bad++; $display("FAIL rst_err_sel: got %b want 0", err_sel); end
    total++; if (drop_cnt !== 8'h00) begin bad++; $display("FAIL rst_drop_cnt: got %h want 00", drop_cnt); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    tick();
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 10'h3FF;
    in_valid = 1'b1; in_sel = 4'd3; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 10'h008) begin bad++; $display("FAIL single_valid: got %h want 008", out_valid); end
    total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL single_data: got %h want a5", out_data); end
    total++; if (out_sel !== 4'd3) begin bad++; $display("FAIL single_sel: got %0d want 3", out_sel); end
    tick();
    total++; if (out_valid !== 10'h000) begin bad++; $display("FAIL single_release: got %h want 000", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 10'h1FF;
    in_valid = 1'b1; in_sel = 4'd9; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 10'h200) begin bad++; $display("FAIL bp_valid[%0d]: got %h want 200", i, out_valid); end
      total++; if (out_data !== 8'h3C) begin bad++; $display("FAIL bp_data[%0d]: got %h want 3c", i, out_data); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      tick();
    end
    out_ready = 10'h3FF;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick();
    total++; if (out_valid !== 10'h000) begin bad++; $display("FAIL bp_released: got %h want 000", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d [3];
    logic [9:0] exp_v;
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    out_ready = 10'h3FF;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sel = 4'(i); in_data = d[i];
      tick();
      exp_v = 10'h001 << i;
      total++; if (out_valid !== exp_v) begin bad++; $display("FAIL b2b_valid[%0d]: got %h want %h", i, out_valid, exp_v); end
      total++; if (out_data !== d[i]) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, out_data, d[i]); end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 10'h000) begin bad++; $display("FAIL b2b_drain: got %h want 000", out_valid); end
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; in_sel = 4'd12; in_data = 8'hFF;
    tick();
    total++; if (err_sel !== 1'b1) begin bad++; $display("FAIL ill12_err: got %b want 1", err_sel); end
    total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL ill12_cnt: got %0d want 1", drop_cnt); end
    total++; if (out_valid !== 10'h000) begin bad++; $display("FAIL ill12_valid: got %h want 000", out_valid); end
    total++; if (out_data !== 8'h33) begin bad++; $display("FAIL ill12_data_kept: got %h want 33", out_data); end
    total++; if (out_sel !== 4'd2) begin bad++; $display("FAIL ill12_sel_kept: got %0d want 2", out_sel); end
    in_sel = 4'd15;
    tick();
    in_valid = 1'b0;
    total++; if (err_sel !== 1'b1) begin bad++; $display("FAIL ill15_err: got %b want 1", err_sel); end
    total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL ill15_cnt: got %0d want 2", drop_cnt); end
    total++; if (out_valid !== 10'h000) begin bad++; $display("FAIL ill15_valid: got %h want 000", out_valid); end
    tick();
    total++; if (err_sel !== 1'b0) begin bad++; $display("FAIL ill_err_clear: got %b want 0", err_sel); end
    total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL ill_cnt_hold: got %0d want 2", drop_cnt); end
  endtask

  task automatic test_illegal_while_hold();
    out_ready = 10'h3FF;
    in_valid = 1'b1; in_sel = 4'd5; in_data = 8'h55;
    tick();
    total++; if (out_valid !== 10'h020) begin bad++; $display("FAIL ih_hold: got %h want 020", out_valid); end
    in_sel = 4'd10; in_data = 8'h66;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ih_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 10'h000) begin bad++; $display("FAIL ih_released: got %h want 000", out_valid); end
    total++; if (err_sel !== 1'b1) begin bad++; $display("FAIL ih_err: got %b want 1", err_sel); end
    total++; if (drop_cnt !== 8'd3) begin bad++; $display("FAIL ih_cnt: got %0d want 3", drop_cnt); end
    total++; if (out_data !== 8'h55) begin bad++; $display("FAIL ih_data_kept: got %h want 55", out_data); end
    tick();
    total++; if (err_sel !== 1'b0) begin bad++; $display("FAIL ih_err_clear: got %b want 0", err_sel); end
  endtask

  task automatic test_saturate();
    in_valid = 1'b1; in_sel = 4'd14; in_data = 8'h00;
    repeat (300) tick();
    in_valid = 1'b0;
    total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt: got %0d want 255", drop_cnt); end
    total++; if (out_valid !== 10'h000) begin bad++; $display("FAIL sat_valid: got %h want 000", out_valid); end
    tick();
    total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL sat_hold: got %0d want 255", drop_cnt); end
    total++; if (err_sel !== 1'b0) begin bad++; $display("FAIL sat_err_clear: got %b want 0", err_sel); end
  endtask

  task automatic test_reset_mid_hold();
    out_ready = 10'h000;
    in_valid = 1'b1; in_sel = 4'd7; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 10'h080) begin bad++; $display("FAIL rmh_hold: got %h want 080", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 10'h000) begin bad++; $display("FAIL rmh_valid: got %h want 000", out_valid); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rmh_cnt: got %0d want 0", drop_cnt); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rmh_data: got %h want 00", out_data); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rmh_ready_low: got %b want 0", in_ready); end
    tick();
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmh_ready_high: got %b want 1", in_ready); end
    out_ready = 10'h3FF;
    in_valid = 1'b1; in_sel = 4'd7; in_data = 8'h7E;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 10'h080) begin bad++; $display("FAIL rmh_fresh_valid: got %h want 080", out_valid); end
    total++; if (out_data !== 8'h7E) begin bad++; $display("FAIL rmh_fresh_data: got %h want 7e", out_data); end
    tick();
    total++; if (out_valid !== 10'h000) begin bad++; $display("FAIL rmh_fresh_release: got %h want 000", out_valid); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sel = 4'd0;
    in_data = 8'h00;
    out_ready = 10'h000;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_illegal_while_hold();
    test_saturate();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
